sdram_wb_bridge: RTL and testbench

Bridge between the CPU-side SDRAM bus (stb/we/sel/adr/ack, 16-bit word) and the SDRAM controller's request/acknowledge interface (separate rd/wr req and ack, 22-bit word address).
It sits directly downstream of the core's SDRAM port and upstream of the SDRAM controller, and runs on the 100 MHz processor clock. It owns:
- the controller reset release sequence;
- the DQM byte-mask generation;
- request latching;
- acknowledge delay and read-data capture.

---
 rtl/sdram_wb_bridge.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_sdram_wb_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wb_bridge.sv
// sdram_wb_bridge
//
// Connects the CPU-side SDRAM bus to the SDRAM controller's request/acknowledge
// interface. The bus side has strobe/ack, a 16-bit word and a 21-bit word
// address. The controller side has separate read and write request/ack pairs
// and a 22-bit word address.
//
// The bridge owns four jobs:
//   - releasing the controller from reset;
//   - generating the DQM byte masks;
//   - latching the request;
//   - delaying the acknowledge and capturing read data.
//
// Optional build macro: SDRAM_TIMEOUT_EN
//   - Defined: a request that waits more than TIMEOUT cycles is forced to
//     finish. The sticky sdram_err flag is set and the bus gets 16'hFFFF.
//   - Undefined: the bridge waits indefinitely and sdram_err is tied low.
//
// Ports
//   clk_p          processor clock; all logic runs on the rising edge
//   sdram_reset    synchronous active-high reset
//   sdram_stb/we/sel/adr/out   bus request (stb held until ack)
//   sdram_dat/ack  bus read data and acknowledge
//   sdram_ready    controller initialised, bridge accepting requests
//   sdram_err      sticky timeout flag
//   ctl_rst_n      controller reset, active low
//   ctl_init_done  controller initialisation complete
//   ctl_rd_req/ctl_wr_req, ctl_rd_ack/ctl_wr_ack   controller handshake
//   ctl_addr/ctl_wdata/ctl_be/ctl_rdata            controller data path
//   dqm_h/dqm_l    SDRAM UDQM/LDQM
module sdram_wb_bridge #(
   parameter int RST_DELAY = 3,
   parameter int ACK_DELAY = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic        clk_p,
   input  logic        sdram_reset,
   input  logic        sdram_stb,
   input  logic        sdram_we,
   input  logic [1:0]  sdram_sel,
   input  logic [20:0] sdram_adr,
   input  logic [15:0] sdram_out,
   output logic [15:0] sdram_dat,
   output logic        sdram_ack,
   output logic        sdram_ready,
   output logic        ctl_rst_n,
   input  logic        ctl_init_done,
   output logic        ctl_wr_req,
   output logic        ctl_rd_req,
   input  logic        ctl_wr_ack,
   input  logic        ctl_rd_ack,
   output logic [21:0] ctl_addr,
   output logic [15:0] ctl_wdata,
   input  logic [15:0] ctl_rdata,
   output logic [1:0]  ctl_be,
   output logic        dqm_h,
   output logic        dqm_l,
   output logic        sdram_err
);

   localparam logic [2:0] S_RSTW  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_IDLE  = 3'd2;
   localparam logic [2:0] S_REQ   = 3'd3;
   localparam logic [2:0] S_DLY   = 3'd4;
   localparam logic [2:0] S_ACK   = 3'd5;
   localparam logic [2:0] S_DRAIN = 3'd6;

   localparam logic [3:0] RST_LAST = 4'(RST_DELAY - 1);
   localparam logic [2:0] ACK_LAST = 3'(ACK_DELAY - 1);

   // Elaboration-time range checks on the parameters.
   if (RST_DELAY < 1 || RST_DELAY > 15) begin : g_bad_rst_delay
      $error("RST_DELAY must be 1..15");
   end
   if (ACK_DELAY < 1 || ACK_DELAY > 7) begin : g_bad_ack_delay
      $error("ACK_DELAY must be 1..7");
   end
   if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
      $error("TIMEOUT must be 1..1023");
   end

   logic [2:0]  state_reg,   state_next;
   logic [3:0]  rst_cnt_reg, rst_cnt_next;
   logic [2:0]  dly_cnt_reg, dly_cnt_next;
   logic        rst_n_reg,   rst_n_next;
   logic        ready_reg,   ready_next;
   logic        ack_reg,     ack_next;
   logic        req_reg,     req_next;
   logic        we_reg,      we_next;
   logic [20:0] addr_reg,    addr_next;
   logic [15:0] wdata_reg,   wdata_next;
   logic [1:0]  be_reg,      be_next;
   logic [1:0]  dqm_reg,     dqm_next;
   logic [15:0] dat_reg,     dat_next;

   logic [1:0]  dqm_lane;
   logic        ack_match;
   logic        to_hit;

   // Reads are always full-word, so both lanes are left unmasked. For writes,
   // a lane is masked (DQM high) when its byte is not selected.
   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_lane
      assign dqm_lane[gi] = sdram_we & ~sdram_sel[gi];
   end

   // Only the ack matching the latched direction completes the request.
   assign ack_match = we_reg ? ctl_wr_ack : ctl_rd_ack;

`ifdef SDRAM_TIMEOUT_EN
   localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

   logic [9:0] to_cnt_reg, to_cnt_next;
   logic       err_reg,    err_next;

   assign to_hit = (to_cnt_reg == TO_LAST);

   // The counter restarts when a request is accepted. It keeps running through
   // DRAIN, so the budget covers the whole life of the controller request.
   always_comb begin
      to_cnt_next = to_cnt_reg;
      err_next    = err_reg;
      if (state_reg == S_IDLE) begin
         to_cnt_next = '0;
      end else if ((state_reg == S_REQ) || (state_reg == S_DRAIN)) begin
         if (!ack_match) begin
            if (to_hit) begin
               err_next = 1'b1;
            end else begin
               to_cnt_next = to_cnt_reg + 10'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_p) begin
      if (sdram_reset) begin
         to_cnt_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         to_cnt_reg <= to_cnt_next;
         err_reg    <= err_next;
      end
   end

   assign sdram_err = err_reg;
`else
   assign to_hit    = 1'b0;
   assign sdram_err = 1'b0;
`endif

   always_comb begin
      state_next   = state_reg;
      rst_cnt_next = rst_cnt_reg;
      dly_cnt_next = dly_cnt_reg;
      rst_n_next   = rst_n_reg;
      ready_next   = ready_reg;
      ack_next     = ack_reg;
      req_next     = req_reg;
      we_next      = we_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      be_next      = be_reg;
      dqm_next     = dqm_reg;
      dat_next     = dat_reg;

      case (state_reg)
         S_RSTW: begin
            if (rst_cnt_reg == RST_LAST) begin
               rst_n_next   = 1'b1;
               rst_cnt_next = '0;
               state_next   = S_INIT;
            end else begin
               rst_cnt_next = rst_cnt_reg + 4'd1;
            end
         end

         S_INIT: begin
            if (ctl_init_done) begin
               ready_next = 1'b1;
               state_next = S_IDLE;
            end
         end

         S_IDLE: begin
            // Losing init_done wins over a new strobe: no request has been
            // accepted yet, so nothing is in progress.
            if (!ctl_init_done) begin
               ready_next = 1'b0;
               state_next = S_INIT;
            end else if (sdram_stb) begin
               we_next    = sdram_we;
               addr_next  = sdram_adr;
               wdata_next = sdram_out;
               be_next    = sdram_sel;
               dqm_next   = dqm_lane;
               req_next   = 1'b1;
               state_next = S_REQ;
            end
         end

         S_REQ: begin
            if (ack_match) begin
               req_next     = 1'b0;
               dly_cnt_next = '0;
               state_next   = S_DLY;
            end else if (to_hit) begin
               req_next = 1'b0;
               dat_next = 16'hFFFF;
               if (sdram_stb) begin
                  ack_next   = 1'b1;
                  state_next = S_ACK;
               end else begin
                  state_next = S_IDLE;
               end
            end else if (!sdram_stb) begin
               // The controller request cannot be withdrawn, so it is seen
               // through to its ack without acknowledging the bus.
               state_next = S_DRAIN;
            end
         end

         S_DRAIN: begin
            if (ack_match) begin
               req_next   = 1'b0;
               state_next = S_IDLE;
            end else if (to_hit) begin
               req_next   = 1'b0;
               dat_next   = 16'hFFFF;
               state_next = S_IDLE;
            end
         end

         S_DLY: begin
            if (dly_cnt_reg == ACK_LAST) begin
               if (!we_reg) begin
                  dat_next = ctl_rdata;
               end
               if (sdram_stb) begin
                  ack_next   = 1'b1;
                  state_next = S_ACK;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               dly_cnt_next = dly_cnt_reg + 3'd1;
            end
         end

         S_ACK: begin
            // Leaving only on a low strobe forces a gap between bus cycles.
            if (!sdram_stb) begin
               ack_next   = 1'b0;
               state_next = S_IDLE;
            end
         end

         default: begin
            state_next = S_RSTW;
         end
      endcase
   end

   always_ff @(posedge clk_p) begin
      if (sdram_reset) begin
         state_reg   <= S_RSTW;
         rst_cnt_reg <= '0;
         dly_cnt_reg <= '0;
         rst_n_reg   <= 1'b0;
         ready_reg   <= 1'b0;
         ack_reg     <= 1'b0;
         req_reg     <= 1'b0;
         we_reg      <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         be_reg      <= '0;
         dqm_reg     <= '0;
         dat_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         rst_cnt_reg <= rst_cnt_next;
         dly_cnt_reg <= dly_cnt_next;
         rst_n_reg   <= rst_n_next;
         ready_reg   <= ready_next;
         ack_reg     <= ack_next;
         req_reg     <= req_next;
         we_reg      <= we_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         be_reg      <= be_next;
         dqm_reg     <= dqm_next;
         dat_reg     <= dat_next;
      end
   end

   // The ack is gated by the live strobe so it falls in the same cycle the
   // bus drops stb.
   assign sdram_ack   = sdram_stb & ack_reg;
   assign sdram_ready = ready_reg;
   assign sdram_dat   = dat_reg;
   assign ctl_rst_n   = rst_n_reg;
   assign ctl_rd_req  = req_reg & ~we_reg;
   assign ctl_wr_req  = req_reg & we_reg;
   assign ctl_addr    = {1'b0, addr_reg};
   assign ctl_wdata   = wdata_reg;
   assign ctl_be      = be_reg;
   assign dqm_h       = dqm_reg[1];
   assign dqm_l       = dqm_reg[0];

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed testbench for sdram_wb_bridge (RST_DELAY=3, ACK_DELAY=2, TIMEOUT=16).
module tb_sdram_wb_bridge;

   logic        clk_p = 1'b0;
   logic        sdram_reset = 1'b1;
   logic        sdram_stb = 1'b0;
   logic        sdram_we = 1'b0;
   logic [1:0]  sdram_sel = 2'b00;
   logic [20:0] sdram_adr = '0;
   logic [15:0] sdram_out = '0;
   logic [15:0] sdram_dat;
   logic        sdram_ack;
   logic        sdram_ready;
   logic        ctl_rst_n;
   logic        ctl_init_done = 1'b0;
   logic        ctl_wr_req;
   logic        ctl_rd_req;
   logic        ctl_wr_ack = 1'b0;
   logic        ctl_rd_ack = 1'b0;
   logic [21:0] ctl_addr;
   logic [15:0] ctl_wdata;
   logic [15:0] ctl_rdata = '0;
   logic [1:0]  ctl_be;
   logic        dqm_h;
   logic        dqm_l;
   logic        sdram_err;

   int n_applied = 0;
   int n_miss    = 0;

   sdram_wb_bridge #(
      .RST_DELAY(3),
      .ACK_DELAY(2),
      .TIMEOUT(16)
   ) dut (
      .clk_p(clk_p), .sdram_reset(sdram_reset),
      .sdram_stb(sdram_stb), .sdram_we(sdram_we), .sdram_sel(sdram_sel),
      .sdram_adr(sdram_adr), .sdram_out(sdram_out), .sdram_dat(sdram_dat),
      .sdram_ack(sdram_ack), .sdram_ready(sdram_ready), .ctl_rst_n(ctl_rst_n),
      .ctl_init_done(ctl_init_done), .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req),
      .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack), .ctl_addr(ctl_addr),
      .ctl_wdata(ctl_wdata), .ctl_rdata(ctl_rdata), .ctl_be(ctl_be),
      .dqm_h(dqm_h), .dqm_l(dqm_l), .sdram_err(sdram_err)
   );

   always #5 clk_p = ~clk_p;

   typedef struct {
      logic        we;
      logic [1:0]  sel;
      logic [20:0] adr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          lat;          // cycles of visible req before the ack
      logic        wrong_first;  // pulse the opposite ack in the first cycle
      logic [21:0] exp_addr;
      logic [1:0]  exp_dqm;      // {dqm_h, dqm_l}
      logic [15:0] exp_dat;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_p);
      #1;
   endtask

   // Reset for 'hold' cycles; init_done rises init_gap cycles after reset low.
   task automatic reset_seq(input int hold, input int init_gap);
      sdram_reset   = 1'b1;
      ctl_init_done = 1'b0;
      sdram_stb     = 1'b0;
      ctl_rd_ack    = 1'b0;
      ctl_wr_ack    = 1'b0;
      repeat (hold) step();
      chk("rst_rst_n",  ctl_rst_n, 0);
      chk("rst_req",    {ctl_wr_req, ctl_rd_req}, 0);
      chk("rst_ack",    sdram_ack, 0);
      chk("rst_ready",  sdram_ready, 0);
      chk("rst_err",    sdram_err, 0);
      chk("rst_dat",    sdram_dat, 0);
      chk("rst_addr",   ctl_addr, 0);
      chk("rst_wdata",  ctl_wdata, 0);
      chk("rst_be",     ctl_be, 0);
      chk("rst_dqm",    {dqm_h, dqm_l}, 0);
      sdram_reset = 1'b0;
      step(); chk("rstn_1", ctl_rst_n, 0);
      step(); chk("rstn_2", ctl_rst_n, 0);
      step(); chk("rstn_3", ctl_rst_n, 1);
      repeat (init_gap - 3) step();
      chk("ready_pre", sdram_ready, 0);
      ctl_init_done = 1'b1;
      step(); chk("ready_post", sdram_ready, 1);
      $display("reset sequence: hold=%0d init_gap=%0d ready=%0b", hold, init_gap, sdram_ready);
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      logic wrong;
      sdram_we  = v.we;
      sdram_sel = v.sel;
      sdram_adr = v.adr;
      sdram_out = v.wdata;
      ctl_rdata = v.rdata;
      sdram_stb = 1'b1;
      step();
      chk("addr",  ctl_addr, v.exp_addr);
      chk("wdata", ctl_wdata, v.wdata);
      chk("be",    ctl_be, v.sel);
      chk("dqm",   {dqm_h, dqm_l}, v.exp_dqm);
      chk("req",   {ctl_wr_req, ctl_rd_req}, v.we ? 2'b10 : 2'b01);
      for (int i = 0; i < v.lat; i++) begin
         wrong = v.wrong_first && (i == 0);
         if (v.we) ctl_rd_ack = wrong; else ctl_wr_ack = wrong;
         step();
         chk("req_hold", {ctl_wr_req, ctl_rd_req}, v.we ? 2'b10 : 2'b01);
         chk("ack_early", sdram_ack, 0);
      end
      ctl_rd_ack = 1'b0;
      ctl_wr_ack = 1'b0;
      if (v.we) ctl_wr_ack = 1'b1; else ctl_rd_ack = 1'b1;
      step();
      ctl_rd_ack = 1'b0;
      ctl_wr_ack = 1'b0;
      chk("req_drop", {ctl_wr_req, ctl_rd_req}, 0);
      chk("ack_dly0", sdram_ack, 0);
      step();
      chk("ack_dly1", sdram_ack, 0);
      step();
      chk("ack_rise", sdram_ack, 1);
      chk("dat",      sdram_dat, v.exp_dat);
      chk("addr_stable", ctl_addr, v.exp_addr);
      step();
      chk("ack_hold", sdram_ack, 1);
      sdram_stb = 1'b0;
      #1;
      chk("ack_fall", sdram_ack, 0);
      step();
      $display("txn %0d: we=%0b sel=%b adr=%h dat=%h dqm=%b", idx, v.we, v.sel, v.adr, sdram_dat, {dqm_h, dqm_l});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //         we    sel    adr        wdata     rdata     lat wrong addr          dqm    dat
      vecs[0] = '{1'b0, 2'b11, 21'h012345, 16'h0000, 16'hA5C3, 6, 1'b0, 22'h012345, 2'b00, 16'hA5C3};
      vecs[1] = '{1'b1, 2'b10, 21'h000100, 16'h7F00, 16'h1234, 3, 1'b0, 22'h000100, 2'b01, 16'hA5C3};
      vecs[2] = '{1'b1, 2'b01, 21'h1FFFFF, 16'h00EE, 16'h5555, 1, 1'b0, 22'h1FFFFF, 2'b10, 16'hA5C3};
      vecs[3] = '{1'b0, 2'b01, 21'h000000, 16'h9999, 16'h0F0F, 2, 1'b1, 22'h000000, 2'b00, 16'h0F0F};
      vecs[4] = '{1'b1, 2'b11, 21'h0ABCDE, 16'hBEEF, 16'h7777, 0, 1'b0, 22'h0ABCDE, 2'b00, 16'h0F0F};
      vecs[5] = '{1'b0, 2'b10, 21'h155555, 16'h0000, 16'h8001, 4, 1'b1, 22'h155555, 2'b00, 16'h8001};
      vecs[6] = '{1'b1, 2'b00, 21'h000001, 16'h1111, 16'h2222, 2, 1'b1, 22'h000001, 2'b11, 16'h8001};

      // Reset release: 5 cycles of reset, init_done 20 cycles after release.
      reset_seq(5, 20);

      for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

      // Abort: stb dropped two cycles after the req, before the controller ack.
      sdram_we = 1'b0; sdram_sel = 2'b11; sdram_adr = 21'h0AAAAA; ctl_rdata = 16'hDEAD;
      sdram_stb = 1'b1;
      step(); chk("abort_req", ctl_rd_req, 1);
      step();
      step();
      sdram_stb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("drain_req", ctl_rd_req, 1);
         chk("drain_ack", sdram_ack, 0);
      end
      ctl_rd_ack = 1'b1;
      step();
      ctl_rd_ack = 1'b0;
      chk("drain_drop", ctl_rd_req, 0);
      step(); step();
      chk("drain_dat", sdram_dat, 16'h8001);
      chk("drain_idle_req", {ctl_wr_req, ctl_rd_req}, 0);
      $display("abort: request drained, dat=%h", sdram_dat);
      v = '{1'b0, 2'b11, 21'h0C0C0C, 16'h0000, 16'h3C3C, 2, 1'b0, 22'h0C0C0C, 2'b00, 16'h3C3C};
      run_txn(v, 7);

      // init_done falling in IDLE drops ready; its return re-raises ready.
      ctl_init_done = 1'b0;
      step(); chk("init_loss_ready", sdram_ready, 0);
      ctl_init_done = 1'b1;
      step(); chk("init_back_ready", sdram_ready, 1);
      $display("init_done loss: ready restored=%0b", sdram_ready);

`ifdef SDRAM_TIMEOUT_EN
      // No controller ack: req lives 16 cycles, then a forced ack with FFFF.
      sdram_we = 1'b0; sdram_sel = 2'b11; sdram_adr = 21'h000777;
      sdram_stb = 1'b1;
      step(); chk("to_req_first", ctl_rd_req, 1);
      for (int i = 1; i < 16; i++) step();
      chk("to_req_last", ctl_rd_req, 1);
      chk("to_err_pre", sdram_err, 0);
      step();
      chk("to_req_drop", ctl_rd_req, 0);
      chk("to_err", sdram_err, 1);
      chk("to_ack", sdram_ack, 1);
      chk("to_dat", sdram_dat, 16'hFFFF);
      sdram_stb = 1'b0;
      step();
      $display("timeout: err=%0b dat=%h", sdram_err, sdram_dat);
      v = '{1'b1, 2'b11, 21'h000123, 16'h4242, 16'h0000, 1, 1'b0, 22'h000123, 2'b00, 16'hFFFF};
      run_txn(v, 8);
      chk("to_err_sticky", sdram_err, 1);
`else
      // No controller ack: the write request is held indefinitely.
      sdram_we = 1'b1; sdram_sel = 2'b11; sdram_adr = 21'h000777; sdram_out = 16'h6666;
      sdram_stb = 1'b1;
      step();
      repeat (40) step();
      chk("noto_req", ctl_wr_req, 1);
      chk("noto_ack", sdram_ack, 0);
      chk("noto_err", sdram_err, 0);
      sdram_stb = 1'b0;
      step();
      ctl_wr_ack = 1'b1;
      step();
      ctl_wr_ack = 1'b0;
      chk("noto_drop", ctl_wr_req, 0);
      chk("noto_dat", sdram_dat, 16'h3C3C);
      $display("no-timeout wait: write drained after 40+ cycles");
`endif

      // Reset pulsed while a read request is outstanding.
      sdram_we = 1'b0; sdram_sel = 2'b11; sdram_adr = 21'h010101; ctl_rdata = 16'h4321;
      sdram_stb = 1'b1;
      step(); chk("midreq_req", ctl_rd_req, 1);
      reset_seq(1, 6);
      v = '{1'b0, 2'b11, 21'h010101, 16'h0000, 16'h4321, 3, 1'b0, 22'h010101, 2'b00, 16'h4321};
      run_txn(v, 9);
`ifndef SDRAM_TIMEOUT_EN
      chk("err_tied", sdram_err, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule
